// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage.
// Each transaction walks IDLE -> ISSUE -> WAIT -> RESP; MEM wins by default, with a bounded streak.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

module mem_bus_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  input  logic [1:0]  mem_req_command,
  input  logic [31:0] mem_req_addr,
  input  logic [31:0] mem_req_data,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  output logic        if_stall,
  output logic        mem_resp_valid,
  output logic [31:0] mem_resp_data,
  output logic        mem_stall,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [31:0] proc2mem_data,
  input  logic        mem2proc_ready,
  input  logic        mem2proc_resp_valid,
  input  logic [31:0] mem2proc_data,
  output logic        bus_timeout_err,
  output logic [1:0]  state_dbg
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STREAK_MAX   = SW'(MAX_DATA_STREAK);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Handshake: a requester holds its request stable until its own one-cycle
  // resp_valid pulse; the memory takes the command in the cycle ready is high
  // and later completes it with exactly one resp_valid.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  state_t state, state_next;

  logic          owner_if;
  logic [1:0]    lat_cmd;
  logic [SW-1:0] streak;
  logic [TW-1:0] wait_cnt;
  logic [31:0]   resp_word;
  logic          mem_pending, grant_if, grant_mem, timeout_hit, in_resp;

  always_comb begin
    mem_pending = (mem_req_command != `BUS_NONE);
    grant_if    = if_req_valid && (!mem_pending || streak == STREAK_MAX);
    grant_mem   = mem_pending && !grant_if;
    timeout_hit = (wait_cnt == TIMEOUT_LAST);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_if || grant_mem) state_next = ISSUE;
      ISSUE:   if (mem2proc_ready) state_next = WAIT;
      WAIT:    if (mem2proc_resp_valid || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The proc2mem registers double as the latched request: loaded on grant,
  // cleared once the memory accepts, so the bus is idle outside ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_if         <= 1'b0;
      lat_cmd          <= `BUS_NONE;
      streak           <= '0;
      wait_cnt         <= '0;
      resp_word        <= '0;
      proc2mem_command <= `BUS_NONE;
      proc2mem_addr    <= '0;
      proc2mem_data    <= '0;
      bus_timeout_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!if_req_valid || grant_if) streak <= '0;
          else if (grant_mem && streak != STREAK_MAX) streak <= streak + SW'(1);
          if (grant_if || grant_mem) begin
            owner_if         <= grant_if;
            lat_cmd          <= grant_if ? `BUS_LOAD : mem_req_command;
            proc2mem_command <= grant_if ? `BUS_LOAD : mem_req_command;
            proc2mem_addr    <= grant_if ? if_req_addr : mem_req_addr;
            proc2mem_data    <= grant_if ? 32'h0 : mem_req_data;
          end
        end
        ISSUE: begin
          if (mem2proc_ready) begin
            proc2mem_command <= `BUS_NONE;
            proc2mem_addr    <= '0;
            proc2mem_data    <= '0;
            wait_cnt         <= '0;
          end
        end
        WAIT: begin
          if (mem2proc_resp_valid) begin
            resp_word <= (lat_cmd == `BUS_STORE) ? 32'h0 : mem2proc_data;
          end else if (timeout_hit) begin
            resp_word       <= 32'h0;
            bus_timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_resp        = (state == RESP);
    if_resp_valid  = in_resp && owner_if;
    mem_resp_valid = in_resp && !owner_if;
    if_resp_data   = if_resp_valid ? resp_word : 32'h0;
    mem_resp_data  = mem_resp_valid ? resp_word : 32'h0;
    if_stall       = if_req_valid && !if_resp_valid;
    mem_stall      = mem_pending && !mem_resp_valid;
    state_dbg      = state;
  end
endmodule
